pc_stack_unit: RTL and testbench



---
 rtl/musa_pc_pkg.sv | 6 +
 rtl/ret_stack.sv | 34 +++
 rtl/pc_stack_unit.sv | 71 +++++++
 tb/tb_pc_stack_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/musa_pc_pkg.sv
// musa_pc_pkg: branch-select and FSM encodings shared by the PC/stack stage.
package musa_pc_pkg;
  typedef enum logic [1:0] {BR_SEQ = 2'b00, BR_COND = 2'b01, BR_ABS = 2'b10, BR_REG = 2'b11} br_t;
  typedef enum logic {S_RUN = 1'b0, S_FAULT = 1'b1} state_t;
  localparam int PC_INC = 4;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO; the parent only issues legal push/pop.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [AW:0] sp_q, sp_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  always_comb begin
    sp_d = push ? sp_q + ONE : pop ? sp_q - ONE : sp_q;
    mem_d = mem_q;
    if (push) mem_d[sp_q[AW-1:0]] = din;
    top = mem_q[sp_q[AW-1:0] - ONE[AW-1:0]];
    empty = sp_q == '0;
    full = sp_q == (AW+1)'(DEPTH);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) sp_q <= '0;
    else sp_q <= sp_d;
  end
  // Popped entries are left in place; they are never read before being rewritten.
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: architectural PC with CALL/RET return stack; a stack fault freezes it until reset.
// Define BRANCH_COUNT_EN to add the saturating taken_cnt output.
module pc_stack_unit
  import musa_pc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_pc,
  input  logic [1:0]        branch,
  input  logic              cond,
  input  logic [ADDR_W-1:0] imm_target,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              push,
  input  logic              pop,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              fault
`ifdef BRANCH_COUNT_EN
  ,output logic [15:0]      taken_cnt
`endif
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, seq, rel, br_pc, raw, top;
  logic err, upd, run, push_en, pop_en;
  ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk(clk), .rst_n(rst_n), .push(push_en), .pop(pop_en), .din(seq),
    .top(top), .empty(stack_empty), .full(stack_full)
  );
  always_comb begin
    seq = pc_q + ADDR_W'(PC_INC);
    rel = seq + imm_target;
    br_pc = branch == BR_SEQ ? seq : branch == BR_COND ? (cond ? rel : seq) :
            branch == BR_ABS ? imm_target : reg_target;
    err = (push & pop) | (push & ret) | (pop & ret) | ((ret | pop) & stack_empty) | (push & stack_full);
    upd = run & write_pc & ~err;
    raw = ret ? top : push ? br_pc : pop ? seq : br_pc;
    pc_d = upd ? raw & ~ADDR_W'(3) : pc_q;
    push_en = upd & push;
    pop_en = upd & (ret | pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  always_comb state_d = (run & write_pc & err) ? S_FAULT : state_q;
  always_comb begin
    run = state_q == S_RUN;
    fault = state_q == S_FAULT;
    pc = pc_q;
  end
`ifdef BRANCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (upd && pc_d != seq && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign taken_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed and random checks of pc_stack_unit against a queue-based reference.
module tb_pc_stack_unit;
  logic clk = 0, rst_n = 0, write_pc = 0, cond = 0, push = 0, pop = 0, ret = 0;
  logic [1:0] branch = 0;
  logic [31:0] imm_target = 0, reg_target = 0, pc;
  logic stack_empty, stack_full, fault;
  int total = 0, bad = 0;
  logic [31:0] pc_m;
  logic [31:0] stk_m[$];
  bit fault_m;
  int cnt_m;
`ifdef BRANCH_COUNT_EN
  logic [15:0] taken_cnt;
`endif
  pc_stack_unit dut (
    .clk(clk), .rst_n(rst_n), .write_pc(write_pc), .branch(branch), .cond(cond),
    .imm_target(imm_target), .reg_target(reg_target), .push(push), .pop(pop), .ret(ret),
    .pc(pc), .stack_empty(stack_empty), .stack_full(stack_full), .fault(fault)
`ifdef BRANCH_COUNT_EN
    , .taken_cnt(taken_cnt)
`endif
  );
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 0;
    write_pc = 1; push = 1; ret = 1;
    @(posedge clk);
    pc_m = 32'h0; stk_m.delete(); fault_m = 0; cnt_m = 0;
    #1;
    rst_n = 1; write_pc = 0; push = 0; ret = 0;
  endtask

  task automatic step(input bit wp, input logic [1:0] br, input bit c, input logic [31:0] imm,
                      input logic [31:0] rg, input bit pu, input bit po, input bit re);
    logic [31:0] seq, tgt, nxt;
    write_pc = wp; branch = br; cond = c; imm_target = imm; reg_target = rg;
    push = pu; pop = po; ret = re;
    @(posedge clk);
    if (!fault_m && wp) begin
      seq = pc_m + 32'd4;
      case (br)
        2'd0: tgt = seq;
        2'd1: tgt = c ? seq + imm : seq;
        2'd2: tgt = imm;
        default: tgt = rg;
      endcase
      if (int'(pu) + int'(po) + int'(re) > 1 || ((re || po) && stk_m.size() == 0) || (pu && stk_m.size() == 8))
        fault_m = 1;
      else begin
        if (re) nxt = stk_m.pop_back();
        else if (pu) begin stk_m.push_back(seq); nxt = tgt; end
        else if (po) begin void'(stk_m.pop_back()); nxt = seq; end
        else nxt = tgt;
        nxt[1:0] = 2'b00;
        if (nxt != seq && cnt_m < 65535) cnt_m++;
        pc_m = nxt;
      end
    end
    #1;
    write_pc = 0; push = 0; pop = 0; ret = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total += 4;
    if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
    if (stack_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", stack_empty); end
    if (stack_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", stack_full); end
    if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b00, 0, 0, 0, 0, 0, 0);
      total++;
      if (pc !== exp_pc[i] || pc !== pc_m) begin bad++; $display("FAIL seq_%0d got=%h exp=%h", i, pc, exp_pc[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 2'b10, 1, 32'h500, 32'h600, 0, 0, 0);
      total++;
      if (pc !== 32'hC) begin bad++; $display("FAIL hold_%0d got=%h exp=0000000c", i, pc); end
    end
  endtask

  task automatic test_branch();
    step(1, 2'b10, 0, 32'h10, 0, 0, 0, 0);
    step(1, 2'b01, 1, 32'hFFFF_FFF0, 0, 0, 0, 0);
    total++;
    if (pc !== 32'h04) begin bad++; $display("FAIL cond_taken got=%h exp=00000004", pc); end
    step(1, 2'b10, 0, 32'h10, 0, 0, 0, 0);
    step(1, 2'b01, 0, 32'hFFFF_FFF0, 0, 0, 0, 0);
    total++;
    if (pc !== 32'h14) begin bad++; $display("FAIL cond_not_taken got=%h exp=00000014", pc); end
    step(1, 2'b11, 0, 0, 32'h103, 0, 0, 0);
    total++;
    if (pc !== 32'h100) begin bad++; $display("FAIL jr_align got=%h exp=00000100", pc); end
  endtask

  task automatic test_call_ret();
    logic [31:0] calls [3];
    calls = '{32'h1000, 32'h2000, 32'h3000};
    do_reset();
    step(1, 2'b10, 0, 32'h20, 0, 0, 0, 0);
    step(1, 2'b10, 0, 32'h200, 0, 1, 0, 0);
    total += 2;
    if (pc !== 32'h200) begin bad++; $display("FAIL call_pc got=%h exp=00000200", pc); end
    if (stack_empty !== 1'b0) begin bad++; $display("FAIL call_empty got=%b exp=0", stack_empty); end
    step(1, 2'b00, 0, 0, 0, 0, 0, 1);
    total += 2;
    if (pc !== 32'h24) begin bad++; $display("FAIL ret_pc got=%h exp=00000024", pc); end
    if (stack_empty !== 1'b1) begin bad++; $display("FAIL ret_empty got=%b exp=1", stack_empty); end
    for (int i = 0; i < 3; i++) step(1, 2'b10, 0, calls[i], 0, 1, 0, 0);
    for (int i = 2; i >= 0; i--) begin
      step(1, 2'b00, 0, 0, 0, 0, 0, 1);
      total++;
      if (pc !== (i == 0 ? 32'h28 : calls[i-1] + 32'h4)) begin
        bad++; $display("FAIL nested_ret_%0d got=%h exp=%h", i, pc, pc_m);
      end
    end
    step(1, 2'b00, 0, 0, 0, 1, 0, 0);
    total++;
    if (pc !== 32'h2C) begin bad++; $display("FAIL push_seq got=%h exp=0000002c", pc); end
    step(1, 2'b10, 0, 32'h800, 0, 0, 1, 0);
    total += 2;
    if (pc !== 32'h30) begin bad++; $display("FAIL pop_pc got=%h exp=00000030", pc); end
    if (stack_empty !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL pop_flags empty=%b fault=%b exp=1,0", stack_empty, fault); end
  endtask

  task automatic test_overflow();
    logic [31:0] frozen;
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 2'b10, 0, 32'h100 * (i + 1), 0, 1, 0, 0);
    total += 2;
    if (stack_full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", stack_full); end
    if (fault !== 1'b0) begin bad++; $display("FAIL full_nofault got=%b exp=0", fault); end
    frozen = pc;
    step(1, 2'b10, 0, 32'h9999_0000, 0, 1, 0, 0);
    total += 2;
    if (fault !== 1'b1) begin bad++; $display("FAIL overflow_fault got=%b exp=1", fault); end
    if (pc !== 32'h800) begin bad++; $display("FAIL overflow_pc got=%h exp=00000800", pc); end
    step(1, 2'b00, 0, 0, 0, 0, 0, 1);
    step(1, 2'b11, 0, 0, 32'h40, 0, 0, 0);
    total += 3;
    if (pc !== frozen) begin bad++; $display("FAIL frozen_pc got=%h exp=%h", pc, frozen); end
    if (stack_full !== 1'b1) begin bad++; $display("FAIL frozen_stack got=%b exp=1", stack_full); end
    if (fault !== 1'b1) begin bad++; $display("FAIL sticky_fault got=%b exp=1", fault); end
    do_reset();
    total += 3;
    if (pc !== 32'h0) begin bad++; $display("FAIL fault_reset_pc got=%h exp=0", pc); end
    if (fault !== 1'b0) begin bad++; $display("FAIL fault_reset_fault got=%b exp=0", fault); end
    if (stack_empty !== 1'b1) begin bad++; $display("FAIL fault_reset_empty got=%b exp=1", stack_empty); end
  endtask

  task automatic test_errors();
    do_reset();
    step(1, 2'b10, 0, 32'h40, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0, 0, 1);
    total += 2;
    if (fault !== 1'b1) begin bad++; $display("FAIL underflow_fault got=%b exp=1", fault); end
    if (pc !== 32'h40) begin bad++; $display("FAIL underflow_pc got=%h exp=00000040", pc); end
    do_reset();
    step(1, 2'b10, 0, 32'h80, 0, 1, 0, 0);
    step(1, 2'b10, 0, 32'h90, 0, 1, 0, 1);
    total += 3;
    if (fault !== 1'b1) begin bad++; $display("FAIL multi_fault got=%b exp=1", fault); end
    if (pc !== 32'h80) begin bad++; $display("FAIL multi_pc got=%h exp=00000080", pc); end
    if (stack_empty !== 1'b0) begin bad++; $display("FAIL multi_sp got=%b exp=0", stack_empty); end
    do_reset();
    step(1, 2'b10, 0, 32'hFFFF_FFFC, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0);
    total += 2;
    if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    if (fault !== 1'b0) begin bad++; $display("FAIL wrap_fault got=%b exp=0", fault); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (fault_m && $urandom_range(0, 3) == 0) do_reset();
      r = $urandom_range(0, 19);
      step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32, $urandom,
           r < 5 || r == 8, (r >= 5 && r < 7) || r == 9, r == 7 || r == 8 || r == 9 || r == 10);
      total++;
      if (pc !== pc_m || stack_empty !== (stk_m.size() == 0) || stack_full !== (stk_m.size() == 8) || fault !== fault_m) begin
        bad++;
        $display("FAIL rand_%0d got pc=%h e=%b f=%b flt=%b exp pc=%h e=%b f=%b flt=%b", i, pc, stack_empty, stack_full, fault,
                 pc_m, stk_m.size() == 0, stk_m.size() == 8, fault_m);
      end
`ifdef BRANCH_COUNT_EN
      total++;
      if (taken_cnt !== 16'(cnt_m)) begin bad++; $display("FAIL rand_cnt_%0d got=%0d exp=%0d", i, taken_cnt, cnt_m); end
`endif
    end
  endtask

`ifdef BRANCH_COUNT_EN
  task automatic test_taken_cnt();
    do_reset();
    step(1, 2'b10, 0, 32'h100, 0, 0, 0, 0);
    step(1, 2'b11, 0, 0, 32'h200, 0, 0, 0);
    step(1, 2'b01, 0, 32'h40, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0);
    total++;
    if (taken_cnt !== 16'd2) begin bad++; $display("FAIL taken_cnt got=%0d exp=2", taken_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_call_ret();
    test_overflow();
    test_errors();
`ifdef BRANCH_COUNT_EN
    test_taken_cnt();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
